// File: rtl/neopixel_pkg.sv
// Shared WS2812 timing constants, tick conversion and the receiver state type.
package neopixel_pkg;

    // Nominal WS2812 line timings in nanoseconds
    localparam int unsigned T0H_NS = 350;
    localparam int unsigned T1H_NS = 700;
    localparam int unsigned T0L_NS = 800;
    localparam int unsigned T1L_NS = 600;
    localparam int unsigned RST_NS = 50_000;

    // Width of the pulse-width / gap counter
    localparam int unsigned CNT_W = 16;

    // Receiver phases; the driver walks the same sequence when generating timing
    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    // Convert a duration in ns to whole clock ticks, truncating any fraction
    function automatic int unsigned ns_to_tck(input longint unsigned clk_hz,
                                              input longint unsigned ns);
        longint unsigned ticks;
        ticks = (clk_hz * ns) / 64'd1_000_000_000;
        return 32'(ticks);
    endfunction

endpackage

// File: rtl/neopixel_sync_edge.sv
// Two-flop synchronizer for the serial line plus registered rise/fall pulses.
// The pulses line up with the first cycle in which o_s_din shows the new level.
module neopixel_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_s_din,
    output logic o_rise,
    output logic o_fall
);

    logic din_p0;
    logic din_p1;
    logic din_p2;

    assign o_s_din = din_p2;

    // Stage p0/p1 resolve metastability, p2 is the registered line used for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            din_p0 <= 1'b0;
            din_p1 <= 1'b0;
            din_p2 <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            din_p0 <= i_din;
            din_p1 <= din_p0;
            din_p2 <= din_p1;
            o_rise <= din_p1 & ~din_p2;
            o_fall <= ~din_p1 & din_p2;
        end
    end

endmodule

// File: rtl/neopixel_receiver.sv
// WS2812 one-wire receiver: measures high-pulse widths, assembles MSB-first
// bytes, writes them to a byte memory from address 0 and reports frame end
// when the line stays low for the reset-gap time.
module neopixel_receiver
    import neopixel_pkg::*;
#(
    parameter int LEDS       = 200,
    parameter int CLK_HZ     = 50_000_000,
    parameter int THRESH_NS  = 525,
    parameter int MIN_HI_NS  = 150,
    parameter int MAX_HI_NS  = 5000,
    parameter int RST_DET_NS = 40_000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_din,
    output logic                           o_wr_en,
    output logic [$clog2(LEDS*3)-1:0]      o_wr_addr,
    output logic [7:0]                     o_wr_data,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic [$clog2(LEDS*3+1)-1:0]    o_frame_bytes,
    output logic                           o_overflow,
    output logic                           o_err
);

    localparam int DEPTH  = LEDS * 3;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int FB_W   = $clog2(DEPTH + 1);
    // Byte index must reach DEPTH+1 so an overflow is remembered
    localparam int IDX_W  = $clog2(DEPTH + 2);

    localparam int unsigned THRESH_TCK  = ns_to_tck(64'(CLK_HZ), 64'(THRESH_NS));
    localparam int unsigned MIN_HI_TCK  = ns_to_tck(64'(CLK_HZ), 64'(MIN_HI_NS));
    localparam int unsigned MAX_HI_TCK  = ns_to_tck(64'(CLK_HZ), 64'(MAX_HI_NS));
    localparam int unsigned RST_DET_TCK = ns_to_tck(64'(CLK_HZ), 64'(RST_DET_NS));

    localparam logic [CNT_W-1:0] THRESH_C  = THRESH_TCK[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MIN_HI_C  = MIN_HI_TCK[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MAX_HI_C  = MAX_HI_TCK[CNT_W-1:0];
    localparam logic [CNT_W-1:0] RST_DET_C = RST_DET_TCK[CNT_W-1:0];

    localparam logic [IDX_W-1:0] DEPTH_I   = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DEPTH + 1);
    localparam logic [FB_W-1:0]  DEPTH_F   = FB_W'(DEPTH);

    // The gap counter is 16 bits wide; a longer reset gap cannot be measured
    if (RST_DET_TCK > 65535) begin : g_rst_det_range
        $error("RST_DET_NS is too long for the 16-bit gap counter at this CLK_HZ");
    end

    // Saturating increment so a stuck line never wraps the counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic             s_din;
    logic             rise;
    logic             fall;

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             bit_val;
    logic [IDX_W-1:0] byte_idx;

    neopixel_sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_din),
        .o_s_din (s_din),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    assign cnt_inc    = sat_inc(cnt);
    assign bit_val    = (cnt >= THRESH_C);
    assign shreg_next = {shreg[6:0], bit_val};

    // Receiver state machine with registered write, frame and error outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= SYNC;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            byte_idx      <= '0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_bytes <= '0;
            o_overflow    <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
            o_err        <= 1'b0;

            case (state)
                // Wait for one full reset gap before trusting the line
                SYNC: begin
                    if (s_din) begin
                        cnt <= '0;
                    end else if (cnt_inc >= RST_DET_C) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // First rising edge opens a frame
                IDLE: begin
                    if (rise) begin
                        state  <= HIGH;
                        cnt    <= CNT_W'(1);
                        o_busy <= 1'b1;
                    end
                end

                // Measure the high pulse; classify or reject on the falling edge
                HIGH: begin
                    if (fall) begin
                        if (cnt < MIN_HI_C) begin
                            o_err    <= 1'b1;
                            o_busy   <= 1'b0;
                            state    <= SYNC;
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            byte_idx <= '0;
                        end else begin
                            shreg   <= shreg_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= LOW;
                            cnt     <= '0;
                            if (bit_cnt == 3'd7) begin
                                if (byte_idx < DEPTH_I) begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_addr <= byte_idx[ADDR_W-1:0];
                                    o_wr_data <= shreg_next;
                                end
                                if (byte_idx != IDX_MAX) begin
                                    byte_idx <= byte_idx + 1'b1;
                                end
                            end
                        end
                    end else if (cnt >= MAX_HI_C) begin
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= SYNC;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // Low time between bits is free; only the reset gap ends the frame
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end else if (cnt_inc >= RST_DET_C) begin
                        o_frame_done  <= 1'b1;
                        o_frame_bytes <= (byte_idx > DEPTH_I) ? DEPTH_F : byte_idx[FB_W-1:0];
                        o_overflow    <= (byte_idx > DEPTH_I);
                        o_err         <= (bit_cnt != 3'd0);
                        o_busy        <= 1'b0;
                        byte_idx      <= '0;
                        bit_cnt       <= '0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state <= SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_receiver.sv
// Bench for neopixel_receiver (LEDS=2): table of pulse-width vectors, directed
// frame sequences and random frames checked against a pulse-list model.
module tb_neopixel_receiver;

    localparam int LEDS   = 2;
    localparam int DEPTH  = LEDS * 3;
    localparam int MIN_HI = 7;
    localparam int THRESH = 26;
    localparam int MAX_HI = 250;
    localparam int GAP    = 2050;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       din   = 1'b0;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [2:0] fbytes;
    logic       ovf;
    logic       err;

    typedef struct {
        int         width;
        logic [7:0] exp_byte;
        int         exp_writes;
        int         exp_err;
    } vec_t;

    int          cmp_n = 0;
    int          fail_n = 0;
    logic [10:0] wr_q[$];
    logic [4:0]  fd_q[$];
    int          err_n = 0;
    int          hi_q[$];
    int          lo_q[$];
    logic        busy_mid;
    logic        busy_end;

    always #5 clk = ~clk;

    neopixel_receiver #(.LEDS(LEDS)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_din         (din),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_frame_done  (done),
        .o_frame_bytes (fbytes),
        .o_overflow    (ovf),
        .o_err         (err)
    );

    // Record every strobe away from the active edge
    always @(negedge clk) begin
        if (wr_en) wr_q.push_back({wr_addr, wr_data});
        if (done) fd_q.push_back({fbytes, ovf, err});
        else if (err) err_n++;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_pulse(input int h, input int l);
        hi_q.push_back(h);
        lo_q.push_back(l);
    endtask

    // Driver-style bit timing: T0H 17 / T0L 40, T1H 35 / T1L 30 ticks
    task automatic add_drv_bits(input logic [7:0] b, input int n);
        for (int k = 7; k > 7 - n; k--) begin
            if (b[k]) add_pulse(35, 30);
            else add_pulse(17, 40);
        end
    endtask

    task automatic send_pulses();
        foreach (hi_q[i]) begin
            hold(1'b1, hi_q[i]);
            hold(1'b0, lo_q[i]);
        end
    endtask

    // Reference: decode the pulse list straight from the timing rules
    task automatic check_frame(input string name, input int wb, input int fb, input int eb);
        logic [10:0] exp_w[$];
        logic [7:0]  cur;
        logic [2:0]  nb_sat;
        logic [4:0]  exp_d;
        int          nbit;
        int          nbytes;
        int          nw;
        logic        aborted;
        cur = 8'h00;
        nbit = 0;
        nbytes = 0;
        aborted = 1'b0;
        foreach (hi_q[i]) begin
            if (!aborted) begin
                if (hi_q[i] < MIN_HI || hi_q[i] > MAX_HI) begin
                    aborted = 1'b1;
                end else begin
                    cur = {cur[6:0], (hi_q[i] >= THRESH)};
                    nbit++;
                    if (nbit % 8 == 0) begin
                        if (nbytes < DEPTH) exp_w.push_back({nbytes[2:0], cur});
                        nbytes++;
                    end
                end
            end
        end
        nw = wr_q.size() - wb;
        chk({name, " write count"}, nw, exp_w.size());
        for (int k = 0; k < exp_w.size() && k < nw; k++)
            chk({name, " write addr/data"}, 32'(wr_q[wb + k]), 32'(exp_w[k]));
        chk({name, " done count"}, fd_q.size() - fb, aborted ? 0 : 1);
        if (!aborted && fd_q.size() > fb) begin
            nb_sat = (nbytes > DEPTH) ? 3'(DEPTH) : 3'(nbytes);
            exp_d  = {nb_sat, (nbytes > DEPTH), (nbit % 8 != 0)};
            chk({name, " done bytes/ovf/err"}, 32'(fd_q[fb]), 32'(exp_d));
        end
        chk({name, " err pulses"}, err_n - eb, aborted ? 1 : 0);
        chk({name, " busy mid"}, 32'(busy_mid), 32'(!aborted));
        chk({name, " busy after gap"}, 32'(busy_end), 32'(0));
    endtask

    task automatic run_frame(input string name);
        int wb;
        int fb;
        int eb;
        wb = wr_q.size();
        fb = fd_q.size();
        eb = err_n;
        send_pulses();
        busy_mid = busy;
        hold(1'b0, GAP);
        busy_end = busy;
        check_frame(name, wb, fb, eb);
        hi_q.delete();
        lo_q.delete();
    endtask

    initial begin
        vec_t tbl[6];
        int   wb;
        int   fb;
        int   eb;

        tbl[0] = '{6,   8'h00, 0, 1};
        tbl[1] = '{7,   8'h00, 1, 0};
        tbl[2] = '{25,  8'h00, 1, 0};
        tbl[3] = '{26,  8'hFF, 1, 0};
        tbl[4] = '{250, 8'hFF, 1, 0};
        tbl[5] = '{251, 8'h00, 0, 1};

        // Reset state
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'({wr_en, wr_addr, wr_data, busy, done, fbytes, ovf, err}), 32'(0));
        rst_n = 1'b1;

        // Idle line: sync, then a second gap in IDLE, never a frame_done
        hold(1'b0, 2 * GAP);
        chk("idle gaps done count", fd_q.size(), 0);
        chk("idle gaps err count", err_n, 0);

        // Table: eight equal pulses per frame at the classification boundaries
        for (int i = 0; i < 6; i++) begin
            wb = wr_q.size();
            fb = fd_q.size();
            eb = err_n;
            for (int p = 0; p < 8; p++) begin
                hold(1'b1, tbl[i].width);
                hold(1'b0, 20);
            end
            hold(1'b0, GAP);
            chk($sformatf("width %0d writes", tbl[i].width), wr_q.size() - wb, tbl[i].exp_writes);
            if (tbl[i].exp_writes == 1 && wr_q.size() > wb)
                chk($sformatf("width %0d data", tbl[i].width), 32'(wr_q[wb]), 32'({3'd0, tbl[i].exp_byte}));
            chk($sformatf("width %0d done", tbl[i].width), fd_q.size() - fb, tbl[i].exp_writes);
            if (tbl[i].exp_writes == 1 && fd_q.size() > fb)
                chk($sformatf("width %0d frame", tbl[i].width), 32'(fd_q[fb]), 32'({3'd1, 2'b00}));
            chk($sformatf("width %0d err", tbl[i].width), err_n - eb, tbl[i].exp_err);
        end

        // Loopback with driver timing
        add_drv_bits(8'hA5, 8);
        add_drv_bits(8'h00, 8);
        add_drv_bits(8'hFF, 8);
        add_drv_bits(8'h3C, 8);
        add_drv_bits(8'h81, 8);
        add_drv_bits(8'h7E, 8);
        run_frame("loopback");
        chk("loopback last write", 32'(wr_q[wr_q.size() - 1]), 32'({3'd5, 8'h7E}));
        chk("loopback frame", 32'(fd_q[fd_q.size() - 1]), 32'({3'd6, 2'b00}));

        // Threshold: 25/26 alternating gives 0x55
        for (int p = 0; p < 8; p++) add_pulse((p % 2 == 0) ? 25 : 26, 40);
        run_frame("threshold");
        chk("threshold byte", 32'(wr_q[wr_q.size() - 1]), 32'({3'd0, 8'h55}));

        // Glitch in byte 2 aborts the frame; next frame restarts at addr 0
        wb = wr_q.size();
        add_drv_bits(8'h12, 8);
        add_drv_bits(8'h34, 8);
        add_drv_bits(8'h56, 3);
        add_pulse(4, 40);
        add_drv_bits(8'h0F, 4);
        run_frame("glitch");
        chk("glitch writes", wr_q.size() - wb, 2);
        add_drv_bits(8'hC3, 8);
        run_frame("after glitch");
        chk("after glitch write", 32'(wr_q[wr_q.size() - 1]), 32'({3'd0, 8'hC3}));

        // Partial byte: 13 bits
        add_drv_bits(8'hA5, 8);
        add_drv_bits(8'h5A, 5);
        run_frame("partial");
        chk("partial frame", 32'(fd_q[fd_q.size() - 1]), 32'({3'd1, 1'b0, 1'b1}));

        // Overflow: 8 bytes into a 6-byte memory
        for (int b = 0; b < 8; b++) add_drv_bits(8'(8'h10 + b), 8);
        run_frame("overflow");
        chk("overflow last write", 32'(wr_q[wr_q.size() - 1]), 32'({3'd5, 8'h15}));
        chk("overflow frame", 32'(fd_q[fd_q.size() - 1]), 32'({3'd6, 1'b1, 1'b0}));

        // Reset after three bytes
        wb = wr_q.size();
        fb = fd_q.size();
        eb = err_n;
        add_drv_bits(8'h11, 8);
        add_drv_bits(8'h22, 8);
        add_drv_bits(8'h33, 8);
        send_pulses();
        hi_q.delete();
        lo_q.delete();
        chk("pre-reset busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-frame reset outputs", 32'({wr_en, wr_addr, wr_data, busy, done, fbytes, ovf, err}), 32'(0));
        rst_n = 1'b1;
        add_drv_bits(8'h44, 8);
        send_pulses();
        hi_q.delete();
        lo_q.delete();
        hold(1'b0, GAP);
        chk("reset writes", wr_q.size() - wb, 3);
        if (wr_q.size() >= wb + 3)
            chk("reset third write", 32'(wr_q[wb + 2]), 32'({3'd2, 8'h33}));
        chk("reset done count", fd_q.size() - fb, 0);
        chk("reset err count", err_n - eb, 0);
        add_drv_bits(8'h99, 8);
        run_frame("after reset");
        chk("after reset write", 32'(wr_q[wr_q.size() - 1]), 32'({3'd0, 8'h99}));

        // Random frames, occasional glitch pulses
        for (int f = 0; f < 4; f++) begin
            int nbits;
            int w;
            nbits = int'($urandom_range(0, 4)) * 8 + int'($urandom_range(0, 7));
            if (nbits == 0) nbits = 1;
            for (int b = 0; b < nbits; b++) begin
                if ($urandom_range(0, 39) == 0) w = int'($urandom_range(1, 6));
                else if ($urandom_range(0, 1) == 1) w = int'($urandom_range(26, 60));
                else w = int'($urandom_range(7, 25));
                add_pulse(w, int'($urandom_range(6, 60)));
            end
            run_frame($sformatf("random frame %0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
